// File: rtl/sobel_pkg.sv
// sobel_pkg: mode encoding, Sobel kernels and gradient headroom shared by the edge engine.
package sobel_pkg;

    typedef enum logic [1:0] {
        MODE_GY     = 2'd0,
        MODE_GX     = 2'd1,
        MODE_SUM    = 2'd2,
        MODE_BYPASS = 2'd3
    } mode_t;

    // Gradients carry this many bits above the pixel width so the signed sums never wrap.
    localparam int GRAD_EXTRA = 4;

    typedef int kernel_t [3][3];

    localparam kernel_t KX = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    localparam kernel_t KY = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: two column-addressed row stores; tap1/tap2 return rows r-1 and r-2 at the addressed column.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int WIDTH = 12,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tap1,
    output logic [WIDTH-1:0] tap2
);

    logic [WIDTH-1:0] row1 [DEPTH];
    logic [WIDTH-1:0] row2 [DEPTH];

    assign tap1 = row1[addr];
    assign tap2 = row2[addr];

    always_ff @(posedge clk)
        if (we) begin
            row1[addr] <= din;
            row2[addr] <= row1[addr];
        end

endmodule

// File: rtl/sobel_edge_engine.sv
// sobel_edge_engine: streaming 3x3 Sobel filter, 2-cycle latency, saturated magnitude output.
// Optional binarisation against thresh when SOBEL_THRESH_EN is defined.
module sobel_edge_engine
    import sobel_pkg::*;
#(
    parameter int PIXEL_SIZE = 12,
    parameter int ROW_SIZE   = 640,
    parameter int COORD_W    = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic                  sof,
    input  logic [PIXEL_SIZE-1:0] pixel_in,
    input  logic [1:0]            mode,
    input  logic [PIXEL_SIZE-1:0] thresh,
    output logic                  valid_out,
    output logic [PIXEL_SIZE-1:0] pixel_out,
    output logic [COORD_W-1:0]    out_x,
    output logic [COORD_W-1:0]    out_y
);

    localparam int GW = PIXEL_SIZE + GRAD_EXTRA;
    localparam int AW = $clog2(ROW_SIZE);
    localparam logic [PIXEL_SIZE-1:0] PMAX = '1;

    logic [COORD_W-1:0]    col, row, pc, pr;
    logic                  qual, last_col;
    mode_t                 mode_q, mode_cur, s1_mode;
    logic [PIXEL_SIZE-1:0] tap1, tap2;
    logic [PIXEL_SIZE-1:0] win [3][3];
    logic                  s1_valid;
    logic [COORD_W-1:0]    s1_x, s1_y;
    logic signed [GW-1:0]  gx, gy;
    logic [GW-1:0]         ax, ay, mag;
    logic [PIXEL_SIZE-1:0] sat, res, fin;

    // An accepted sof places its own pixel at (0,0) and latches that frame's mode.
    assign pc       = sof ? '0 : col;
    assign pr       = sof ? '0 : row;
    assign last_col = pc == COORD_W'(ROW_SIZE - 1);
    assign qual     = valid_in && pr >= COORD_W'(2) && pc >= COORD_W'(2);
    assign mode_cur = (valid_in && sof) ? mode_t'(mode) : mode_q;

    sobel_line_buffer #(
        .DEPTH(ROW_SIZE),
        .WIDTH(PIXEL_SIZE)
    ) u_lines (
        .clk (clk),
        .we  (valid_in),
        .addr(pc[AW-1:0]),
        .din (pixel_in),
        .tap1(tap1),
        .tap2(tap2)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            mode_q   <= MODE_GY;
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_mode  <= MODE_GY;
        end else begin
            s1_valid <= qual;
            if (valid_in) begin
                col     <= last_col ? '0 : pc + 1'b1;
                row     <= last_col ? pr + 1'b1 : pr;
                mode_q  <= mode_cur;
                s1_x    <= pc - 1'b1;
                s1_y    <= pr - 1'b1;
                s1_mode <= mode_cur;
            end
        end

    // Window row 0 is the oldest line (r-2), column 2 the newest pixel (c).
    always_ff @(posedge clk)
        if (valid_in) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= tap2;
            win[1][2] <= tap1;
            win[2][2] <= pixel_in;
        end

    always_comb begin
        gx = '0;
        gy = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                gx = gx + GW'(KX[i][j]) * $signed({{GRAD_EXTRA{1'b0}}, win[i][j]});
                gy = gy + GW'(KY[i][j]) * $signed({{GRAD_EXTRA{1'b0}}, win[i][j]});
            end
        ax  = gx[GW-1] ? GW'(-gx) : GW'(gx);
        ay  = gy[GW-1] ? GW'(-gy) : GW'(gy);
        mag = s1_mode == MODE_GX ? ax : s1_mode == MODE_GY ? ay : ax + ay;
        sat = |mag[GW-1:PIXEL_SIZE] ? PMAX : mag[PIXEL_SIZE-1:0];
        res = s1_mode == MODE_BYPASS ? win[1][1] : sat;
    end

`ifdef SOBEL_THRESH_EN
    assign fin = s1_mode == MODE_BYPASS ? res : (sat >= thresh ? PMAX : '0);
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh;
    assign fin = res;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            valid_out <= 1'b0;
            pixel_out <= '0;
            out_x     <= '0;
            out_y     <= '0;
        end else begin
            valid_out <= s1_valid;
            if (s1_valid) begin
                pixel_out <= fin;
                out_x     <= s1_x;
                out_y     <= s1_y;
            end
        end

endmodule

// File: tb/tb_sobel_edge_engine.sv
// tb_sobel_edge_engine: directed frames with hand-derived expected outputs, coordinates and latency.
module tb_sobel_edge_engine;

    localparam int P  = 12;
    localparam int RS = 8;
    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_in = 1'b0;
    logic          sof = 1'b0;
    logic [P-1:0]  pixel_in = '0;
    logic [1:0]    mode = 2'd0;
    logic [P-1:0]  thresh = '0;
    logic          valid_out;
    logic [P-1:0]  pixel_out;
    logic [CW-1:0] out_x, out_y;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int ov[$], ox[$], oy[$], oc[$];
    int icyc [0:7][0:7];

    sobel_edge_engine #(
        .PIXEL_SIZE(P),
        .ROW_SIZE(RS),
        .COORD_W(CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (valid_in),
        .sof      (sof),
        .pixel_in (pixel_in),
        .mode     (mode),
        .thresh   (thresh),
        .valid_out(valid_out),
        .pixel_out(pixel_out),
        .out_x    (out_x),
        .out_y    (out_y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (valid_out === 1'b1) begin
            ov.push_back(int'(pixel_out));
            ox.push_back(int'(out_x));
            oy.push_back(int'(out_y));
            oc.push_back(cyc);
        end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [P-1:0] pix(input int pat, input int r, input int c);
        case (pat)
            0:       return P'(100);
            1:       return c >= 4 ? P'(100) : P'(0);
            2:       return r >= 2 ? P'(4095) : P'(0);
            3:       return P'(c * 10 + r * 20);
            default: return P'(200 - 20 * r);
        endcase
    endfunction

    // Hand-derived results: step edges give 4*delta, the ramp gives |Gx|=80, |Gy|=160.
    function automatic int exp_val(input int pat, input int m, input int x, input int y);
        int v;
        case (pat)
            0:       v = 0;
            1:       v = (x == 3 || x == 4) ? 400 : 0;
            2:       v = m == 3 ? (y >= 2 ? 4095 : 0) : (y <= 2 ? 4095 : 0);
            3:       v = m == 3 ? x * 10 + y * 20 : 240;
            default: v = 160;
        endcase
`ifdef SOBEL_THRESH_EN
        if (m != 3) v = v >= int'(thresh) ? 4095 : 0;
`endif
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
            sof = 1'b0;
            pixel_in = P'($urandom);
        end
    endtask

    task automatic px(input logic s, input logic [P-1:0] v, input int md, input int r, input int c);
        @(negedge clk);
        valid_in = 1'b1;
        sof = s;
        pixel_in = v;
        mode = 2'(md);
        icyc[r][c] = cyc;
    endtask

    // Mode input changes after the first pixel to show the latched mode holds for the frame.
    task automatic frame(input int pat, input int m, input int rows, input int last_cols,
                         input logic use_sof, input logic gap);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < (r == rows - 1 ? last_cols : RS); c++) begin
                px(use_sof && r == 0 && c == 0, pix(pat, r, c), (r == 0 && c == 0) ? m : (m ^ 1), r, c);
                if (gap) idle($urandom_range(0, 3));
            end
    endtask

    task automatic clear_out();
        ov.delete();
        ox.delete();
        oy.delete();
        oc.delete();
    endtask

    task automatic check_frame(input string nm, input int pat, input int m, input int n);
        int x, y;
        chk({nm, "_count"}, ov.size(), n);
        for (int i = 0; i < ov.size() && i < n; i++) begin
            x = i % 6 + 1;
            y = i / 6 + 1;
            chk($sformatf("%s_x[%0d]", nm, i), ox[i], x);
            chk($sformatf("%s_y[%0d]", nm, i), oy[i], y);
            chk($sformatf("%s_val[%0d]", nm, i), ov[i], exp_val(pat, m, x, y));
            chk($sformatf("%s_lat[%0d]", nm, i), oc[i], icyc[y + 1][x + 1] + 2);
        end
        clear_out();
    endtask

    initial begin
        idle(2);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_pixel_out", pixel_out, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_out_y", out_y, 0);
        rst_n = 1'b1;
        idle(2);

        frame(0, 2, 5, RS, 1'b1, 1'b0);
        idle(4);
        check_frame("const_sum", 0, 2, 18);

        thresh = P'(300);
        frame(1, 1, 5, RS, 1'b1, 1'b0);
        idle(4);
        check_frame("vstep_t300", 1, 1, 18);

        thresh = P'(401);
        frame(1, 1, 5, RS, 1'b1, 1'b0);
        idle(4);
        check_frame("vstep_t401", 1, 1, 18);

        thresh = P'(1);
        frame(2, 2, 5, RS, 1'b1, 1'b0);
        idle(4);
        check_frame("hstep_sum", 2, 2, 18);
        frame(2, 0, 5, RS, 1'b1, 1'b0);
        idle(4);
        check_frame("hstep_gy", 2, 0, 18);
        frame(2, 3, 5, RS, 1'b1, 1'b0);
        idle(4);
        check_frame("hstep_byp", 2, 3, 18);

        frame(3, 2, 5, RS, 1'b1, 1'b0);
        idle(4);
        check_frame("ramp_sum", 3, 2, 18);
        frame(4, 0, 5, RS, 1'b1, 1'b0);
        idle(4);
        check_frame("ramp_gy", 4, 0, 18);
        frame(3, 3, 5, RS, 1'b1, 1'b0);
        idle(4);
        check_frame("ramp_byp", 3, 3, 18);

        frame(1, 1, 5, RS, 1'b1, 1'b1);
        idle(4);
        check_frame("gaps", 1, 1, 18);

        // Restart at c=5 of row 3: old frame yields 9 outputs, new frame 6.
        frame(1, 1, 4, 5, 1'b1, 1'b0);
        frame(3, 3, 3, RS, 1'b1, 1'b0);
        idle(4);
        chk("midsof_count", ov.size(), 15);
        if (ov.size() == 15) begin
            chk("midsof_old_x", ox[8], 3);
            chk("midsof_old_y", oy[8], 2);
            chk("midsof_old_val", ov[8], exp_val(1, 1, 3, 2));
            chk("midsof_new_x", ox[9], 1);
            chk("midsof_new_y", oy[9], 1);
            chk("midsof_new_val", ov[9], exp_val(3, 3, 1, 1));
            chk("midsof_new_lat", oc[9], icyc[2][2] + 2);
            chk("midsof_last_val", ov[14], exp_val(3, 3, 6, 1));
        end
        clear_out();

        frame(2, 0, 3, 4, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_pre_valid", valid_out, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", valid_out, 0);
        chk("rst_mid_pixel", pixel_out, 0);
        chk("rst_mid_x", out_x, 0);
        idle(3);
        rst_n = 1'b1;
        idle(4);
        chk("rst_mid_dropped", ov.size(), 0);
        clear_out();

        frame(2, 3, 5, RS, 1'b0, 1'b0);
        idle(4);
        check_frame("nosof", 2, 0, 18);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
